// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix scan codes, frame-state encoding and the
// queued key-event record.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } frame_state_e;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_evt_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with registered occupancy count; a pop frees
// room for a same-cycle push when full.
module sync_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push, pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];
   assign pop     = rd_en && !empty;
   assign push    = wr_en && (!full || pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame checking, E0/F0
// prefix folding and a FWFT event queue read via valid/ready.
module ps2_key_event_queue
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 20000,
   parameter int unsigned DEPTH          = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ps2_clk,
   input  logic                   ps2_data,
   input  logic                   evt_ready,
   input  logic                   clr_err,
   output logic                   evt_valid,
   output logic [7:0]             evt_code,
   output logic                   evt_ext,
   output logic                   evt_brk,
   output logic [$clog2(DEPTH):0] evt_count,
   output logic                   overflow,
   output logic                   frame_err
);

   localparam int unsigned FLT_W = $clog2(FILTER_LEN);
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

   logic clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
   logic filt_q, filt_d;
   logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
   logic fall;

   frame_state_e state_q, state_d;
   logic [2:0]   bit_cnt_q, bit_cnt_d;
   logic [7:0]   shift_q, shift_d;
   logic         parity_q, parity_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic         ext_q, ext_d, brk_q, brk_d;
   logic         emit_q, emit_d;
   ps2_evt_t     emit_evt_q, emit_evt_d;
   logic         frame_err_q, frame_err_d;
   logic         overflow_q, overflow_d;
   logic         err_set;

   ps2_evt_t head;
   logic     fifo_full, fifo_empty, pop, drop;

   // Edge is accepted only after the pin has disagreed with the filter for FILTER_LEN cycles
   always_comb begin
      filt_d    = filt_q;
      flt_cnt_d = '0;
      if (clk_sync_q != filt_q) begin
         if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
            filt_d = clk_sync_q;
         end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
         end
      end
   end

   assign fall = filt_q && !filt_d;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      tmo_cnt_d  = '0;
      ext_d      = ext_q;
      brk_d      = brk_q;
      emit_d     = 1'b0;
      emit_evt_d = emit_evt_q;
      err_set    = 1'b0;

      if (state_q != ST_IDLE && !fall) begin
         if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_IDLE;
            err_set = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
         end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
      end

      if (fall) begin
         case (state_q)
            ST_IDLE: begin
               if (!data_sync_q) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end
            end
            ST_DATA: begin
               shift_d   = {data_sync_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               parity_d = data_sync_q;
               state_d  = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (data_sync_q && (^{shift_q, parity_q})) begin
                  if (shift_q == PS2_EXT) begin
                     ext_d = 1'b1;
                  end else if (shift_q == PS2_BRK) begin
                     brk_d = 1'b1;
                  end else begin
                     emit_d     = 1'b1;
                     emit_evt_d = '{ext: ext_q, brk: brk_q, code: shift_q};
                     ext_d      = 1'b0;
                     brk_d      = 1'b0;
                  end
               end else begin
                  err_set = 1'b1;
                  ext_d   = 1'b0;
                  brk_d   = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign pop  = !fifo_empty && evt_ready;
   assign drop = emit_q && fifo_full && !pop;

   always_comb begin
      frame_err_d = frame_err_q;
      overflow_d  = overflow_q;
      if (clr_err) begin
         frame_err_d = 1'b0;
         overflow_d  = 1'b0;
      end
      if (err_set) frame_err_d = 1'b1;
      if (drop)    overflow_d  = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
         filt_q      <= 1'b1;
         flt_cnt_q   <= '0;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         tmo_cnt_q   <= '0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         emit_q      <= 1'b0;
         emit_evt_q  <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         clk_meta_q  <= ps2_clk;
         clk_sync_q  <= clk_meta_q;
         data_meta_q <= ps2_data;
         data_sync_q <= data_meta_q;
         filt_q      <= filt_d;
         flt_cnt_q   <= flt_cnt_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         tmo_cnt_q   <= tmo_cnt_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         emit_q      <= emit_d;
         emit_evt_q  <= emit_evt_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(ps2_evt_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (emit_q),
      .wr_data (emit_evt_q),
      .rd_en   (evt_ready),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (evt_count)
   );

   assign evt_valid = !fifo_empty;
   assign evt_code  = head.code;
   assign evt_ext   = head.ext;
   assign evt_brk   = head.brk;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;

endmodule
